wb_ram_loader: RTL

WB_RAM_LOADER -- requirements
Module: wb_ram_loader

---
 rtl/wb_ram_loader_pkg.sv | 17 +
 rtl/wb_ram_loader_pack.sv | 46 ++++
 rtl/wb_ram_loader.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_ram_loader_pkg.sv
// Shared types and constants for the Wishbone RAM loader: FSM state
// encoding, word geometry and the byte-index width used by the packer.
package wb_ram_loader_pkg;

  localparam int BYTES_PER_WORD = 4;
  localparam int BIDX_W         = $clog2(BYTES_PER_WORD);
  localparam int WORD_W         = 8 * BYTES_PER_WORD;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    WRITE,
    VERIFY,
    DONE
  } state_e;

endpackage

// File: rtl/wb_ram_loader_pack.sv
// Byte-to-word packer: collects BYTES_PER_WORD bytes little-endian (first
// byte lands in [7:0]) and flags the cycle in which the last byte arrives.
// word_o is valid together with word_valid_o, so the caller can register it
// on the same edge that accepts the final byte.
module wb_ram_loader_pack
  import wb_ram_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              clear_i,
  input  logic              push_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_valid_o
);

  localparam logic [BIDX_W-1:0] LAST_IDX = BIDX_W'(BYTES_PER_WORD - 1);
  localparam logic [BIDX_W-1:0] IDX_ONE  = BIDX_W'(1);

  logic [BIDX_W-1:0] cnt_q;
  logic [WORD_W-1:0] shift_q;
  logic [WORD_W-1:0] shift_d;

  // Next shift-register value: new byte enters at the top, older bytes
  // move toward [7:0], giving little-endian order after a full word.
  // NOTE: combinational blocks assign every output on every path so no latch is inferred.
  always_comb begin
    shift_d = {byte_i, shift_q[WORD_W-1:8]};
  end

  assign word_o       = shift_d;
  assign word_valid_o = push_i && (cnt_q == LAST_IDX);

  // Byte counter and shift register; clear discards any partial word.
  // NOTE: sequential state uses non-blocking assignments so all registers update together at the edge.
  always_ff @(posedge clk_i) begin
    if (rst_in || clear_i) begin
      cnt_q   <= '0;
      shift_q <= '0;
    end else if (push_i) begin
      shift_q <= shift_d;
      cnt_q   <= (cnt_q == LAST_IDX) ? '0 : cnt_q + IDX_ONE;
    end
  end

endmodule

// File: rtl/wb_ram_loader.sv
// Wishbone RAM loader: packs a byte stream into 32-bit words and writes
// them to consecutive word addresses (wrapping modulo DEPTH) through a
// classic Wishbone master port. One write per word, never back-to-back stb.
// Optional build macro LOADER_VERIFY_EN: each write is followed by a
// read-back of the same address; a mismatch sets the sticky err_o.
// done_o is a registered pulse issued as the FSM leaves DONE.
module wb_ram_loader
  import wb_ram_loader_pkg::*;
#(
  parameter  int DEPTH = 1024,
  localparam int ADR_W = $clog2(DEPTH)
) (
  input  logic              clk_i,
  input  logic              rst_in,
  input  logic              start_i,
  input  logic [ADR_W-1:0]  base_i,
  input  logic [ADR_W:0]    len_i,
  input  logic              s_valid_i,
  input  logic [7:0]        s_data_i,
  output logic              s_ready_o,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [3:0]        wb_sel_o,
  output logic [ADR_W-1:0]  wb_adr_o,
  output logic [WORD_W-1:0] wb_dat_o,
  input  logic              wb_ack_i,
  input  logic [WORD_W-1:0] wb_dat_i
);

  localparam logic [ADR_W-1:0] ADR_LAST = ADR_W'(DEPTH - 1);
  localparam logic [ADR_W-1:0] ADR_ONE  = ADR_W'(1);
  localparam logic [ADR_W:0]   CNT_ONE  = (ADR_W + 1)'(1);

  state_e            state_q;
  logic [ADR_W-1:0]  adr_q;
  logic [ADR_W-1:0]  adr_d;
  logic [ADR_W:0]    cnt_q;
  logic [ADR_W:0]    cnt_d;
  logic              cyc_q;
  logic              stb_q;
  logic              we_q;
  logic [3:0]        sel_q;
  logic [WORD_W-1:0] dat_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;

  logic              push;
  logic              pack_clear;
  logic              word_valid;
  logic [WORD_W-1:0] word;

  assign push       = s_valid_i && ready_q;
  assign pack_clear = (state_q == IDLE) && start_i;

  wb_ram_loader_pack u_pack (
    .clk_i       (clk_i),
    .rst_in      (rst_in),
    .clear_i     (pack_clear),
    .push_i      (push),
    .byte_i      (s_data_i),
    .word_o      (word),
    .word_valid_o(word_valid)
  );

  // Address/count values after one completed word; address wraps at DEPTH.
  always_comb begin
    adr_d = (adr_q == ADR_LAST) ? '0 : adr_q + ADR_ONE;
    cnt_d = cnt_q - CNT_ONE;
  end

`ifdef LOADER_VERIFY_EN
  logic err_q;
  assign err_o = err_q;
`else
  logic unused_rd_dat;
  assign unused_rd_dat = ^wb_dat_i;
  assign err_o         = 1'b0;
`endif

  // Main FSM with registered outputs; acks outside an active cycle are ignored.
  always_ff @(posedge clk_i) begin
    if (rst_in) begin
      state_q <= IDLE;
      adr_q   <= '0;
      cnt_q   <= '0;
      cyc_q   <= 1'b0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef LOADER_VERIFY_EN
      err_q   <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            adr_q  <= base_i;
            cnt_q  <= len_i;
            busy_q <= 1'b1;
`ifdef LOADER_VERIFY_EN
            err_q  <= 1'b0;
`endif
            if (len_i == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= COLLECT;
              ready_q <= 1'b1;
            end
          end
        end

        COLLECT: begin
          if (word_valid) begin
            ready_q <= 1'b0;
            dat_q   <= word;
            cyc_q   <= 1'b1;
            stb_q   <= 1'b1;
            we_q    <= 1'b1;
            sel_q   <= 4'hF;
            state_q <= WRITE;
          end
        end

        WRITE: begin
          if (wb_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            we_q  <= 1'b0;
            sel_q <= '0;
`ifdef LOADER_VERIFY_EN
            state_q <= VERIFY;
`else
            adr_q <= adr_d;
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= COLLECT;
              ready_q <= 1'b1;
            end
`endif
          end
        end

`ifdef LOADER_VERIFY_EN
        // First cycle here is the idle gap after the write; then one read.
        VERIFY: begin
          if (!cyc_q) begin
            cyc_q <= 1'b1;
            stb_q <= 1'b1;
            sel_q <= 4'hF;
          end else if (wb_ack_i) begin
            cyc_q <= 1'b0;
            stb_q <= 1'b0;
            sel_q <= '0;
            if (wb_dat_i != dat_q) begin
              err_q <= 1'b1;
            end
            adr_q <= adr_d;
            cnt_q <= cnt_d;
            if (cnt_d == '0) begin
              state_q <= DONE;
            end else begin
              state_q <= COLLECT;
              ready_q <= 1'b1;
            end
          end
        end
`endif

        DONE: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign s_ready_o = ready_q;
  assign busy_o    = busy_q;
  assign done_o    = done_q;
  assign wb_cyc_o  = cyc_q;
  assign wb_stb_o  = stb_q;
  assign wb_we_o   = we_q;
  assign wb_sel_o  = sel_q;
  assign wb_adr_o  = adr_q;
  assign wb_dat_o  = dat_q;

endmodule
